fp_sqrt_seq: RTL and testbench

//  IEEE-754 single-precision square-root sequencer. Sits directly upstream of the integer sqrt unit.

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_sqrt_unpack.sv | 45 ++++
 rtl/fp_sqrt_seq.sv | 131 +++++++++++++
 tb/tb_fp_sqrt_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision square-root sequencer.
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;
   localparam int BIAS_DEF  = 127;

   // Canonical quiet NaN and positive infinity (single precision).
   localparam logic [31:0] QNAN = 32'h7FC00000;
   localparam logic [31:0] PINF = 32'h7F800000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_RES,
      S_PACK,
      S_DONE
   } state_t;

endpackage

// File: rtl/fp_sqrt_unpack.sv
// Combinational operand decode: classification flags, significand,
// even-adjusted unbiased exponent and the integer radicand for the root unit.
module fp_sqrt_unpack import fp_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int BIAS  = BIAS_DEF
) (
   input  logic [EXP_W+MAN_W:0]         a,
   output logic                         is_nan,
   output logic                         is_inf,
   output logic                         is_zero,
   output logic                         is_neg,
   output logic [MAN_W:0]               m,
   output logic signed [EXP_W:0]        e_adj,
   output logic                         odd,
   output logic [2*(MAN_W+1)-1:0]       radicand
);

   localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);

   logic [EXP_W-1:0]      exp_f;
   logic [MAN_W-1:0]      man_f;
   logic signed [EXP_W:0] e;

   // Field split, classification and radicand build; denormals count as zero.
   always_comb begin
      exp_f   = a[EXP_W+MAN_W-1:MAN_W];
      man_f   = a[MAN_W-1:0];
      is_neg  = a[EXP_W+MAN_W];
      is_nan  = (&exp_f) && (man_f != '0);
      is_inf  = (&exp_f) && (man_f == '0);
      is_zero = (exp_f == '0);
      m       = {1'b1, man_f};
      e       = $signed({1'b0, exp_f}) - BIAS_S;
      odd     = e[0];
      e_adj   = e - $signed({{EXP_W{1'b0}}, odd});
      // An odd exponent folds its extra factor of two into the radicand, so the
      // root always lands in [2^MAN_W, 2^(MAN_W+1)).
      if (odd)
         radicand = {m, {(MAN_W+1){1'b0}}};
      else
         radicand = {1'b0, m, {MAN_W{1'b0}}};
   end

endmodule

// File: rtl/fp_sqrt_seq.sv
// Single-precision square-root sequencer: resolves special operands locally and
// drives an external integer square-root unit for normal positive operands.
module fp_sqrt_seq import fp_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int BIAS  = BIAS_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [EXP_W+MAN_W:0]         a,
   output logic                         ready,
   output logic                         done,
   output logic [EXP_W+MAN_W:0]         result,
   output logic                         isqrt_start,
   output logic [2*(MAN_W+1)-1:0]       isqrt_radicand,
   input  logic                         isqrt_ready,
   input  logic [MAN_W:0]               isqrt_root
);

   localparam int W = EXP_W + MAN_W + 1;
   localparam logic [W-1:0] NAN_Q = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [W-1:0] INF_P = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

   state_t state, state_n;

   logic [W-1:0]                op;
   logic [EXP_W-1:0]            exp_q;
   logic [MAN_W-1:0]            root_q;

   logic                        is_nan, is_inf, is_zero, is_neg, odd, special;
   logic [MAN_W:0]              m;
   logic signed [EXP_W:0]       e_adj, e_half;
   logic signed [EXP_W+1:0]     exp_calc;
   logic [2*(MAN_W+1)-1:0]      rad_w;

   // The significand, parity flag, root MSB (always 1) and exponent carry bits
   // are not needed downstream; collected here so they are visibly intentional.
   logic unused_bits;
   assign unused_bits = ^{m, odd, isqrt_root[MAN_W], exp_calc[EXP_W+1:EXP_W]};

   fp_sqrt_unpack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .BIAS  (BIAS)
   ) u_unpack (
      .a        (op),
      .is_nan   (is_nan),
      .is_inf   (is_inf),
      .is_zero  (is_zero),
      .is_neg   (is_neg),
      .m        (m),
      .e_adj    (e_adj),
      .odd      (odd),
      .radicand (rad_w)
   );

   assign special  = is_nan | is_inf | is_zero | is_neg;
   assign e_half   = e_adj >>> 1;
   assign exp_calc = {e_half[EXP_W], e_half} + (EXP_W+2)'(BIAS);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_n     = state;
      ready       = 1'b0;
      done        = 1'b0;
      isqrt_start = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start)
               state_n = S_DECODE;
         end
         S_DECODE:   state_n = special ? S_DONE : S_ISSUE;
         S_ISSUE: begin
            isqrt_start = 1'b1;
            state_n     = S_WAIT_ACK;
         end
         S_WAIT_ACK: if (!isqrt_ready) state_n = S_WAIT_RES;
         S_WAIT_RES: if (isqrt_ready)  state_n = S_PACK;
         S_PACK:     state_n = S_DONE;
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default:    state_n = S_IDLE;
      endcase
   end

   // Operand, radicand, exponent, root and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op             <= '0;
         isqrt_radicand <= '0;
         exp_q          <= '0;
         root_q         <= '0;
         result         <= '0;
      end else begin
         if (state == S_IDLE && start)
            op <= a;
         if (state == S_DECODE) begin
            if (is_nan)
               result <= NAN_Q;
            else if (is_zero)
               result <= {is_neg, {(W-1){1'b0}}};
            else if (is_neg)
               result <= NAN_Q;
            else if (is_inf)
               result <= INF_P;
            else begin
               isqrt_radicand <= rad_w;
               exp_q          <= exp_calc[EXP_W-1:0];
            end
         end
         if (state == S_WAIT_RES && isqrt_ready)
            root_q <= isqrt_root[MAN_W-1:0];
         // Truncated root: the hidden bit is dropped, no remainder rounding.
         if (state == S_PACK)
            result <= {1'b0, exp_q, root_q};
      end
   end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Bench for fp_sqrt_seq with a behavioural integer square-root unit and a
// scoreboard of expected results checked whenever done pulses.
module tb_fp_sqrt_seq;
   import fp_pkg::*;

   logic        clk, rst, start;
   logic [31:0] a;
   logic        ready, done, isqrt_start, isqrt_ready;
   logic [31:0] result;
   logic [47:0] isqrt_radicand;
   logic [23:0] isqrt_root;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int busy = 3;
   logic [31:0] sb[$];

   fp_sqrt_seq dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .a              (a),
      .ready          (ready),
      .done           (done),
      .result         (result),
      .isqrt_start    (isqrt_start),
      .isqrt_radicand (isqrt_radicand),
      .isqrt_ready    (isqrt_ready),
      .isqrt_root     (isqrt_root)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] isqrt48(input logic [47:0] v);
      logic [23:0] r, t;
      logic [47:0] tt;
      r = '0;
      for (int b = 23; b >= 0; b--) begin
         t  = r | (24'd1 << b);
         tt = 48'(t) * 48'(t);
         if (tt <= v) r = t;
      end
      return r;
   endfunction

   // Reference: specials by rule, normals via double-precision sqrt truncated.
   function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] mf;
      logic [63:0] db, rb;
      real         d, r;
      int          fe;
      e  = x[30:23];
      mf = x[22:0];
      if (e == 8'hFF && mf != 0) return QNAN;
      if (e == 8'h00) return {x[31], 31'b0};
      if (x[31]) return QNAN;
      if (e == 8'hFF) return PINF;
      db = {1'b0, 11'(int'(e) - 127 + 1023), mf, 29'b0};
      d  = $bitstoreal(db);
      r  = $sqrt(d);
      rb = $realtobits(r);
      fe = int'(rb[62:52]) - 1023 + 127;
      return {1'b0, fe[7:0], rb[51:29]};
   endfunction

   // Behavioural integer unit: ready drops the cycle after launch, result after busy cycles.
   logic [23:0] m_pend;
   int          m_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         isqrt_ready <= 1'b1;
         isqrt_root  <= '0;
         m_pend      <= '0;
         m_cnt       <= 0;
      end else if (isqrt_ready && isqrt_start) begin
         isqrt_ready <= 1'b0;
         m_pend      <= isqrt48(isqrt_radicand);
         m_cnt       <= busy;
      end else if (!isqrt_ready) begin
         if (m_cnt <= 1) begin
            isqrt_ready <= 1'b1;
            isqrt_root  <= m_pend;
         end
         m_cnt <= m_cnt - 1;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      logic [31:0] expv;
      if (!rst) begin
         if (isqrt_start) start_cnt++;
         if (done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: result=%h, required no done pulse", result);
            end else begin
               expv = sb.pop_front();
               if (result !== expv) begin
                  errors++;
                  $display("FAIL sb_result: got %h required %h", result, expv);
               end
            end
         end
      end
   end

   task automatic do_op(input logic [31:0] op, input logic [31:0] expv,
                        output int lat, output int starts, output int dones);
      int s0, d0, k;
      @(negedge clk);
      a = op;
      start = 1'b1;
      sb.push_back(expv);
      s0 = start_cnt;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!done && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL timeout: op=%h no done after %0d cycles", op, k);
         lat = -1;
      end else begin
         lat = k + 1;
      end
      @(posedge clk); #1;
      starts = start_cnt - s0;
      dones  = done_cnt - d0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0;
      repeat (3) @(posedge clk);
      #1;
      checks += 5;
      if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ready); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
      if (isqrt_start !== 1'b0) begin errors++; $display("FAIL rst_isqrt_start: got %b required 0", isqrt_start); end
      if (result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h required 0", result); end
      if (isqrt_radicand !== 48'h0) begin errors++; $display("FAIL rst_radicand: got %h required 0", isqrt_radicand); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_normal();
      int lat, st, dn;
      busy = 3;
      do_op(32'h40800000, 32'h40000000, lat, st, dn);
      checks += 3;
      if (st !== 1) begin errors++; $display("FAIL four_starts: got %0d required 1", st); end
      if (dn !== 1) begin errors++; $display("FAIL four_dones: got %0d required 1", dn); end
      if (lat !== 5 + busy) begin errors++; $display("FAIL four_latency: got %0d required %0d", lat, 5 + busy); end
      do_op(32'h40000000, 32'h3FB504F3, lat, st, dn);
      checks += 2;
      if (isqrt_radicand !== (48'h800000 << 24)) begin
         errors++; $display("FAIL two_radicand: got %h required %h", isqrt_radicand, 48'h800000 << 24);
      end
      if (result !== 32'h3FB504F3) begin errors++; $display("FAIL two_result: got %h required 3fb504f3", result); end
      do_op(32'h3E800000, 32'h3F000000, lat, st, dn);
      do_op(32'h3F800000, 32'h3F800000, lat, st, dn);
      busy = 6;
      do_op(32'h41100000, 32'h40400000, lat, st, dn);
      checks++;
      if (lat !== 5 + busy) begin errors++; $display("FAIL nine_latency: got %0d required %0d", lat, 5 + busy); end
   endtask

   task automatic test_special();
      logic [31:0] ops[6];
      logic [31:0] exps[6];
      int lat, st, dn;
      ops = '{32'hBF800000, 32'h7F800000, 32'h80000000, 32'h00000001, 32'h7F812345, 32'h80000005};
      exps = '{QNAN, PINF, 32'h80000000, 32'h00000000, QNAN, 32'h80000000};
      foreach (ops[i]) begin
         do_op(ops[i], exps[i], lat, st, dn);
         checks += 2;
         if (lat !== 2) begin errors++; $display("FAIL special_latency: op=%h got %0d required 2", ops[i], lat); end
         if (st !== 0) begin errors++; $display("FAIL special_isqrt_start: op=%h got %0d required 0", ops[i], st); end
      end
   endtask

   task automatic test_start_ignored();
      int k, s0;
      busy = 4;
      @(negedge clk);
      a = 32'h40000000;
      start = 1'b1;
      sb.push_back(32'h3FB504F3);
      s0 = start_cnt;
      @(posedge clk); #1;
      k = 0;
      while (!done && k < 400) begin
         a = 32'h41100000;
         start = 1'b1;
         checks++;
         if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: cycle %0d got %b required 0", k, ready); end
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      checks++;
      if (!done) begin errors++; $display("FAIL ignore_timeout: no done after %0d cycles", k); end
      @(posedge clk); #1;
      checks += 2;
      if (start_cnt - s0 !== 1) begin errors++; $display("FAIL ignore_starts: got %0d required 1", start_cnt - s0); end
      if (ready !== 1'b1) begin errors++; $display("FAIL ignore_idle_ready: got %b required 1", ready); end
   endtask

   task automatic test_reset_mid();
      int k, lat, st, dn;
      busy = 5;
      @(negedge clk);
      a = 32'h40800000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!isqrt_start && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (!isqrt_start) begin errors++; $display("FAIL midrst_launch: isqrt_start never seen"); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks += 3;
      if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", ready); end
      if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b required 0", done); end
      if (isqrt_start !== 1'b0) begin errors++; $display("FAIL midrst_isqrt_start: got %b required 0", isqrt_start); end
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      do_op(32'h41100000, 32'h40400000, lat, st, dn);
      checks++;
      if (dn !== 1) begin errors++; $display("FAIL midrst_fresh_dones: got %0d required 1", dn); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] op;
      int lat, st, dn;
      for (int i = 0; i < 24; i++) begin
         busy = 3 + int'($urandom_range(0, 4));
         if (i % 6 == 5)
            op = {1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom)};
         else
            op = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
         do_op(op, ref_sqrt(op), lat, st, dn);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_special();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
